brc_arbiter: RTL and testbench

//  Shares one brc branch comparator between two requesters, e.g. the

---
 rtl/brc_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_brc_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/brc_arbiter.sv
//==============================================================================
// Module   : brc_arbiter
// Purpose  : Round-robin sharing of one branch comparator between two
//            requesters, with RV32I funct3 decode and a registered tagged
//            response. Optional perf counters are added when BRC_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module brc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_eq,
    output logic             o_lt
);
    always_comb begin
        o_eq = (i_a == i_b);
        if (i_signed) begin
            o_lt = ($signed(i_a) < $signed(i_b));
        end else begin
            o_lt = (i_a < i_b);
        end
    end
endmodule

module brc_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [31:0]      i_req0_rs1,
    input  logic [31:0]      i_req0_rs2,
    input  logic [2:0]       i_req0_funct3,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req1_rs1,
    input  logic [31:0]      i_req1_rs2,
    input  logic [2:0]       i_req1_funct3,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_port,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_taken,
    output logic             o_rsp_illegal
`ifdef BRC_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] o_perf_taken_cnt,
    output logic [CNT_W-1:0] o_perf_stall_cnt
`endif
);

    if (TAG_W < 1 || CNT_W < 1) begin : g_param_check
        $error("brc_arbiter: TAG_W and CNT_W must be at least 1");
    end

    logic             r_rsp_valid_q,   w_rsp_valid_d;
    logic             r_rsp_port_q,    w_rsp_port_d;
    logic [TAG_W-1:0] r_rsp_tag_q,     w_rsp_tag_d;
    logic             r_rsp_taken_q,   w_rsp_taken_d;
    logic             r_rsp_illegal_q, w_rsp_illegal_d;
    logic             r_last_grant_q,  w_last_grant_d;

    logic             w_slot_free;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [31:0]      w_rs1;
    logic [31:0]      w_rs2;
    logic [2:0]       w_funct3;
    logic [TAG_W-1:0] w_tag;
    logic             w_eq;
    logic             w_lt;
    logic             w_taken;
    logic             w_illegal;

    assign w_slot_free = ~r_rsp_valid_q | i_rsp_ready;

    // Grants are gated by reset so readies stay low while i_rst_n is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst_n && w_slot_free) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt0 = r_last_grant_q;
                w_gnt1 = ~r_last_grant_q;
            end else begin
                w_gnt0 = i_req0_valid;
                w_gnt1 = i_req1_valid;
            end
        end
    end

    assign w_accept     = w_gnt0 | w_gnt1;
    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    always_comb begin
        w_rs1    = w_gnt1 ? i_req1_rs1    : i_req0_rs1;
        w_rs2    = w_gnt1 ? i_req1_rs2    : i_req0_rs2;
        w_funct3 = w_gnt1 ? i_req1_funct3 : i_req0_funct3;
        w_tag    = w_gnt1 ? i_req1_tag    : i_req0_tag;
    end

    brc #(
        .WIDTH (32)
    ) u_brc (
        .i_a      (w_rs1),
        .i_b      (w_rs2),
        .i_signed (~w_funct3[1]),
        .o_eq     (w_eq),
        .o_lt     (w_lt)
    );

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = ~w_eq;
            3'b100,
            3'b110:  w_taken = w_lt;
            3'b101,
            3'b111:  w_taken = ~w_lt;
            default: w_illegal = 1'b1;
        endcase
    end

    // A pop and an accept in the same cycle overwrite the slot in place.
    always_comb begin
        w_rsp_valid_d   = r_rsp_valid_q & ~i_rsp_ready;
        w_rsp_port_d    = r_rsp_port_q;
        w_rsp_tag_d     = r_rsp_tag_q;
        w_rsp_taken_d   = r_rsp_taken_q;
        w_rsp_illegal_d = r_rsp_illegal_q;
        w_last_grant_d  = r_last_grant_q;
        if (w_accept) begin
            w_rsp_valid_d   = 1'b1;
            w_rsp_port_d    = w_gnt1;
            w_rsp_tag_d     = w_tag;
            w_rsp_taken_d   = w_taken;
            w_rsp_illegal_d = w_illegal;
            w_last_grant_d  = w_gnt1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_valid_q   <= 1'b0;
            r_rsp_port_q    <= 1'b0;
            r_rsp_tag_q     <= '0;
            r_rsp_taken_q   <= 1'b0;
            r_rsp_illegal_q <= 1'b0;
            r_last_grant_q  <= 1'b1;
        end else begin
            r_rsp_valid_q   <= w_rsp_valid_d;
            r_rsp_port_q    <= w_rsp_port_d;
            r_rsp_tag_q     <= w_rsp_tag_d;
            r_rsp_taken_q   <= w_rsp_taken_d;
            r_rsp_illegal_q <= w_rsp_illegal_d;
            r_last_grant_q  <= w_last_grant_d;
        end
    end

    assign o_rsp_valid   = r_rsp_valid_q;
    assign o_rsp_port    = r_rsp_port_q;
    assign o_rsp_tag     = r_rsp_tag_q;
    assign o_rsp_taken   = r_rsp_taken_q;
    assign o_rsp_illegal = r_rsp_illegal_q;

`ifdef BRC_ARB_PERF_EN
    logic [CNT_W-1:0] r_taken_cnt_q, w_taken_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt_q, w_stall_cnt_d;
    logic             w_stall;

    assign w_stall = (i_req0_valid & ~w_gnt0) | (i_req1_valid & ~w_gnt1);

    always_comb begin
        w_taken_cnt_d = r_taken_cnt_q;
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_accept && w_taken && !w_illegal) begin
            w_taken_cnt_d = r_taken_cnt_q + 1'b1;
        end
        if (w_stall) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_taken_cnt_q <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_taken_cnt_q <= w_taken_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign o_perf_taken_cnt = r_taken_cnt_q;
    assign o_perf_stall_cnt = r_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_brc_arbiter.sv
//==============================================================================
// Module   : tb_brc_arbiter
// Purpose  : Directed and randomized checks of brc_arbiter against a
//            behavioural model of the arbitration and branch rules.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_brc_arbiter;

    localparam int TAG_W = 4;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             v0, v1;
    logic [31:0]      a0, b0, a1, b1;
    logic [2:0]       f0, f1;
    logic [TAG_W-1:0] t0, t1;
    logic             rsp_ready;
    logic             rdy0, rdy1;
    logic             rsp_valid, rsp_port, rsp_taken, rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;
`ifdef BRC_ARB_PERF_EN
    logic [CNT_W-1:0] perf_taken, perf_stall;
`endif

    brc_arbiter #(
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req0_valid  (v0),
        .o_req0_ready  (rdy0),
        .i_req0_rs1    (a0),
        .i_req0_rs2    (b0),
        .i_req0_funct3 (f0),
        .i_req0_tag    (t0),
        .i_req1_valid  (v1),
        .o_req1_ready  (rdy1),
        .i_req1_rs1    (a1),
        .i_req1_rs2    (b1),
        .i_req1_funct3 (f1),
        .i_req1_tag    (t1),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_port    (rsp_port),
        .o_rsp_tag     (rsp_tag),
        .o_rsp_taken   (rsp_taken),
        .o_rsp_illegal (rsp_illegal)
`ifdef BRC_ARB_PERF_EN
        ,
        .o_perf_taken_cnt (perf_taken),
        .o_perf_stall_cnt (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit      m_init = 0;
    bit      m_fresh = 0;
    bit      m_valid = 0;
    int      m_port = 0;
    int      m_tag = 0;
    bit      m_taken = 0;
    bit      m_illegal = 0;
    int      m_last = 1;
    longint  m_taken_cnt = 0;
    longint  m_stall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        case (f)
            3'd0:    return ux == uy;
            3'd1:    return ux != uy;
            3'd4:    return sx <  sy;
            3'd5:    return sx >= sy;
            3'd6:    return ux <  uy;
            3'd7:    return ux >= uy;
            default: return 1'b0;
        endcase
    endfunction

    // Which port the rules say should be granted: -1 none, else 0/1.
    function automatic int ref_grant();
        bit free = !m_valid || rsp_ready;
        if (!rst_n || !free) return -1;
        if (v0 && v1) return 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Inputs are set after a falling edge; check, then advance one clock.
    task automatic tick();
        int g;
        #1;
        g = ref_grant();
        check("req0_ready", {31'd0, rdy0}, {31'd0, g == 0});
        check("req1_ready", {31'd0, rdy1}, {31'd0, g == 1});
        if (m_init) begin
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            if (m_valid || m_fresh) begin
                check("rsp_port",    {31'd0, rsp_port},    m_port);
                check("rsp_tag",     {28'd0, rsp_tag},     m_tag);
                check("rsp_taken",   {31'd0, rsp_taken},   {31'd0, m_taken});
                check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, m_illegal});
            end
`ifdef BRC_ARB_PERF_EN
            check("perf_taken", perf_taken, m_taken_cnt[31:0]);
            check("perf_stall", perf_stall, m_stall_cnt[31:0]);
`endif
        end
        @(posedge clk);
        if (!rst_n) begin
            m_init = 1; m_fresh = 1; m_valid = 0; m_port = 0; m_tag = 0;
            m_taken = 0; m_illegal = 0; m_last = 1; m_taken_cnt = 0; m_stall_cnt = 0;
        end else begin
            m_fresh = 0;
            if ((v0 && g != 0) || (v1 && g != 1)) m_stall_cnt++;
            if (g >= 0) begin
                m_valid   = 1;
                m_port    = g;
                m_tag     = (g == 0) ? int'(t0) : int'(t1);
                m_illegal = (g == 0) ? (f0 inside {3'd2, 3'd3}) : (f1 inside {3'd2, 3'd3});
                m_taken   = (g == 0) ? ref_taken(f0, a0, b0) : ref_taken(f1, a1, b1);
                m_last    = g;
                if (m_taken && !m_illegal) m_taken_cnt++;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        v0 = 0; v1 = 0;
    endtask

    initial begin
        logic [TAG_W-1:0] held_tag;
        rst_n = 0; rsp_ready = 1; idle();
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; f0 = 0; f1 = 0; t0 = 0; t1 = 0;
        @(negedge clk);
        tick(); tick();
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_tag",   {28'd0, rsp_tag},   32'd0);
        rst_n = 1;

        // BLT signed: -1 < 1
        v0 = 1; a0 = 32'hFFFF_FFFF; b0 = 32'd1; f0 = 3'b100; t0 = 4'd3;
        tick(); idle();
        check("t1_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_taken", {31'd0, rsp_taken}, 32'd1);
        check("t1_port",  {31'd0, rsp_port},  32'd0);

        // BLTU / BGEU unsigned on port 1
        v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'd1; f1 = 3'b110; t1 = 4'd5;
        tick();
        check("t2_bltu_taken", {31'd0, rsp_taken}, 32'd0);
        check("t2_bltu_port",  {31'd0, rsp_port},  32'd1);
        f1 = 3'b111; t1 = 4'd6;
        tick(); idle();
        check("t2_bgeu_taken", {31'd0, rsp_taken}, 32'd1);

        // Contention: alternating 0,1,0,1 with matching tags
        for (int i = 0; i < 4; i++) begin
            v0 = 1; v1 = 1; f0 = 3'b000; f1 = 3'b001;
            t0 = TAG_W'(2 * i); t1 = TAG_W'(2 * i + 1);
            tick();
            check("t3_order_port", {31'd0, rsp_port}, i % 2);
            check("t3_order_tag",  {28'd0, rsp_tag},  (i % 2 == 0) ? 2 * i : 2 * i + 1);
        end

        // Back-pressure: result held, no grants, then pop+accept
        rsp_ready = 0; held_tag = rsp_tag;
        for (int i = 0; i < 3; i++) tick();
        check("t4_hold_tag", {28'd0, rsp_tag}, {28'd0, held_tag});
        rsp_ready = 1; v1 = 0; v0 = 1; t0 = 4'd9; f0 = 3'b101;
        tick(); idle();
        check("t4_pop_accept_valid", {31'd0, rsp_valid}, 32'd1);
        check("t4_pop_accept_tag",   {28'd0, rsp_tag},   32'd9);

        // Illegal funct3
        v0 = 1; f0 = 3'b011; t0 = 4'd10; a0 = 5; b0 = 5;
        tick(); idle();
        check("t5_illegal", {31'd0, rsp_illegal}, 32'd1);
        check("t5_taken",   {31'd0, rsp_taken},   32'd0);

        // Reset while a result is held
        v0 = 1; f0 = 3'b000; tick(); idle(); rsp_ready = 0;
        tick();
        rst_n = 0; tick();
        check("t6_reset_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1; rsp_ready = 1; v0 = 1; v1 = 1; t0 = 4'd1; t1 = 4'd2;
        tick(); idle();
        check("t6_first_tie_port", {31'd0, rsp_port}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom_range(0, 7)) - 32'd4;
            f0 = 3'($urandom); f1 = 3'($urandom);
            t0 = TAG_W'($urandom); t1 = TAG_W'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
